i_fetch: RTL and testbench

Instruction-fetch stage of the five-stage RV32I pipeline; sits directly upstream of the decode stage and fills the IF/ID buffer (`IF_ID_stage_t`). It owns the PC register and issues one read at a time to the instruction cache, holding the request stable until `imem_resp`. It absorbs back-pressure from the hazard unit and applies branch/jump redirects from EX, including discarding a response that is already in flight.

---
 rtl/i_fetch.sv | 194 +++++++++++++++++++
 tb/tb_i_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/i_fetch.sv
// RV32I instruction-fetch stage: owns the PC, keeps one instruction-cache read
// in flight, and fills the IF/ID buffer while absorbing stalls and EX redirects.
package i_fetch_pkg;

    typedef struct packed {
        logic [31:0] word;
    } ir_t;

    typedef struct packed {
        logic        rvfi_valid;
        logic [63:0] rvfi_order;
        logic [31:0] rvfi_insn;
        logic [4:0]  rvfi_rs1_addr;
        logic [4:0]  rvfi_rs2_addr;
        logic [31:0] rvfi_rs1_rdata;
        logic [31:0] rvfi_rs2_rdata;
        logic [4:0]  rvfi_rd_addr;
        logic [31:0] rvfi_rd_wdata;
        logic [31:0] rvfi_pc_rdata;
        logic [31:0] rvfi_pc_wdata;
        logic [31:0] rvfi_mem_addr;
        logic [3:0]  rvfi_mem_rmask;
        logic [3:0]  rvfi_mem_wmask;
        logic [31:0] rvfi_mem_rdata;
        logic [31:0] rvfi_mem_wdata;
    } rvfi_t;

    typedef struct packed {
        logic [31:0] pc;
        ir_t         ir;
        rvfi_t       rvfi_d;
    } IF_ID_stage_t;

endpackage

module i_fetch
    import i_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    output logic         imem_read,
    output logic [31:0]  imem_address,
    input  logic [31:0]  imem_rdata,
    input  logic         imem_resp,
    output IF_ID_stage_t if_out,
    output logic         if_valid
);

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_npc_q, out_npc_d;
    logic [31:0] out_ir_q, out_ir_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_ir_q, hold_ir_d;
    logic [31:0] disc_addr_q, disc_addr_d;
    logic        slot_free_s;
    logic        consume_s;

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            out_pc_q    <= 32'h0000_0000;
            out_npc_q   <= 32'h0000_0000;
            out_ir_q    <= NOP_WORD;
            valid_q     <= 1'b0;
            hold_pc_q   <= 32'h0000_0000;
            hold_ir_q   <= 32'h0000_0000;
            disc_addr_q <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_pc_q    <= out_pc_d;
            out_npc_q   <= out_npc_d;
            out_ir_q    <= out_ir_d;
            valid_q     <= valid_d;
            hold_pc_q   <= hold_pc_d;
            hold_ir_q   <= hold_ir_d;
            disc_addr_q <= disc_addr_d;
        end
    end

    // Next-state logic: redirect outranks stall and response in every state.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_pc_d    = out_pc_q;
        out_npc_d   = out_npc_q;
        out_ir_d    = out_ir_q;
        valid_d     = valid_q;
        hold_pc_d   = hold_pc_q;
        hold_ir_d   = hold_ir_q;
        disc_addr_d = disc_addr_q;
        slot_free_s = !valid_q || !stall_i;
        consume_s   = valid_q && !stall_i;

        case (state_q)
            FETCH: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    valid_d = 1'b0;
                    if (imem_resp) begin
                        state_d = FETCH;
                    end else begin
                        // The cache request cannot be withdrawn; remember its address.
                        state_d     = DISCARD;
                        disc_addr_d = pc_q;
                    end
                end else if (imem_resp) begin
                    pc_d = pc_q + 32'd4;
                    if (slot_free_s) begin
                        out_pc_d  = pc_q;
                        out_npc_d = pc_q + 32'd4;
                        out_ir_d  = imem_rdata;
                        valid_d   = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        hold_pc_d = pc_q;
                        hold_ir_d = imem_rdata;
                        state_d   = HOLD;
                    end
                end else if (consume_s) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (slot_free_s) begin
                    out_pc_d  = hold_pc_q;
                    out_npc_d = hold_pc_q + 32'd4;
                    out_ir_d  = hold_ir_q;
                    valid_d   = 1'b1;
                    state_d   = FETCH;
                end else begin
                    state_d = HOLD;
                end
            end
            DISCARD: begin
                valid_d = 1'b0;
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = DISCARD;
                end else if (imem_resp) begin
                    state_d = FETCH;
                end else begin
                    state_d = DISCARD;
                end
            end
            default: begin
                state_d = FETCH;
                valid_d = 1'b0;
            end
        endcase
    end

    // Output decode: cache request and IF/ID buffer contents come straight from state.
    always_comb begin
        imem_read    = !rst && (state_q != HOLD);
        imem_address = 32'h0000_0000;
        if (state_q == DISCARD) begin
            imem_address = {disc_addr_q[31:2], 2'b00};
        end else begin
            imem_address = {pc_q[31:2], 2'b00};
        end
        if_out                      = '0;
        if_out.pc                   = out_pc_q;
        if_out.ir.word              = valid_q ? out_ir_q : NOP_WORD;
        if_out.rvfi_d.rvfi_pc_rdata = out_pc_q;
        if_out.rvfi_d.rvfi_pc_wdata = out_npc_q;
        if_valid                    = valid_q;
    end

endmodule

// File: tb/tb_i_fetch.sv
// Bench for i_fetch: directed vector table, a reset-in-DISCARD sequence, then
// random stall/redirect/cache-latency traffic against a queue-based reference model.
module tb_i_fetch;
    import i_fetch_pkg::*;

    logic         clk;
    logic         rst;
    logic         stall_i;
    logic         redirect_i;
    logic [31:0]  redirect_pc_i;
    logic         imem_read;
    logic [31:0]  imem_address;
    logic [31:0]  imem_rdata;
    logic         imem_resp;
    IF_ID_stage_t if_out;
    logic         if_valid;

    int errors = 0;
    int checks = 0;

    i_fetch #(.RESET_PC(32'h4000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .if_out       (if_out),
        .if_valid     (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        resp;
        logic [31:0] rdata;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eir;
        logic        erd;
        logic [31:0] eaddr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } ent_t;

    vec_t vecs [17];

    // Reference model state: queue front is the output slot, a second entry is the held one.
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic        m_stale;
    logic [31:0] m_stale_addr;
    logic [31:0] m_out_pc;
    logic        m_loaded;

    function automatic vec_t mk(logic st, logic rd, logic [31:0] rpc, logic rs, logic [31:0] dat,
                                logic ev, logic [31:0] epc, logic [31:0] eir, logic erd,
                                logic [31:0] eaddr);
        vec_t v;
        v.stall = st; v.redirect = rd; v.rpc = rpc; v.resp = rs; v.rdata = dat;
        v.ev = ev; v.epc = epc; v.eir = eir; v.erd = erd; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic erd, input logic [31:0] eaddr,
                             input logic ev, input logic [31:0] epc, input logic [31:0] eir,
                             input logic [31:0] ewdata);
        rvfi_t t;
        t = if_out.rvfi_d;
        t.rvfi_pc_rdata = 32'h0;
        t.rvfi_pc_wdata = 32'h0;
        chk({tag, ".read"},  {31'h0, imem_read}, {31'h0, erd});
        chk({tag, ".addr"},  imem_address, eaddr);
        chk({tag, ".valid"}, {31'h0, if_valid}, {31'h0, ev});
        chk({tag, ".pc"},    if_out.pc, epc);
        chk({tag, ".ir"},    if_out.ir.word, eir);
        chk({tag, ".rvfi_pc_rdata"}, if_out.rvfi_d.rvfi_pc_rdata, epc);
        chk({tag, ".rvfi_pc_wdata"}, if_out.rvfi_d.rvfi_pc_wdata, ewdata);
        chk({tag, ".rvfi_zero"}, {31'h0, (t == '0)}, 32'h1);
    endtask

    function automatic void model_reset();
        mq.delete();
        m_pc         = 32'h4000_0000;
        m_stale      = 1'b0;
        m_stale_addr = 32'h0;
        m_out_pc     = 32'h0;
        m_loaded     = 1'b0;
    endfunction

    // Advance the model by one clock edge given the inputs sampled at that edge.
    function automatic void model_step(logic r, logic st, logic rd, logic [31:0] rpc,
                                       logic rs, logic [31:0] dat);
        int  sz;
        bit  holding;
        if (r) begin
            model_reset();
            return;
        end
        sz      = mq.size();
        holding = (sz == 2);
        if (rd) begin
            if (!m_stale && !holding && !rs) begin
                m_stale      = 1'b1;
                m_stale_addr = m_pc;
            end
            mq.delete();
            m_pc = rpc;
        end else begin
            if (sz > 0 && !st) void'(mq.pop_front());
            if (m_stale) begin
                if (rs) m_stale = 1'b0;
            end else if (!holding && rs) begin
                mq.push_back('{m_pc, dat});
                m_pc = m_pc + 32'd4;
            end
        end
        if (mq.size() > 0) begin
            m_out_pc = mq[0].pc;
            m_loaded = 1'b1;
        end
    endfunction

    initial begin
        int          lat;
        logic        r_rst, r_st, r_rd, r_rs, exp_rd;
        logic [31:0] r_rpc, r_dat, exp_addr;

        vecs[0]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0093, 1'b1, 32'h4000_0000, 32'h0000_0093, 1'b1, 32'h4000_0004);
        vecs[1]  = mk(1'b1, 1'b0, 32'h0, 1'b1, 32'h0010_0113, 1'b1, 32'h4000_0000, 32'h0000_0093, 1'b0, 32'h4000_0008);
        vecs[2]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h4000_0000, 32'h0000_0093, 1'b0, 32'h4000_0008);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h4000_0000, 32'h0000_0093, 1'b0, 32'h4000_0008);
        vecs[4]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 32'h4000_0004, 32'h0010_0113, 1'b1, 32'h4000_0008);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0020_0193, 1'b1, 32'h4000_0008, 32'h0020_0193, 1'b1, 32'h4000_000C);
        vecs[6]  = mk(1'b0, 1'b1, 32'h4000_1000, 1'b0, 32'h0, 1'b0, 32'h4000_0008, 32'h0000_0013, 1'b1, 32'h4000_000C);
        vecs[7]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 32'h4000_0008, 32'h0000_0013, 1'b1, 32'h4000_000C);
        vecs[8]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h4000_0008, 32'h0000_0013, 1'b1, 32'h4000_1000);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0030_0213, 1'b1, 32'h4000_1000, 32'h0030_0213, 1'b1, 32'h4000_1004);
        vecs[10] = mk(1'b1, 1'b1, 32'h4000_2000, 1'b1, 32'hCAFE_F00D, 1'b0, 32'h4000_1000, 32'h0000_0013, 1'b1, 32'h4000_2000);
        vecs[11] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h4000_1000, 32'h0000_0013, 1'b1, 32'h4000_2000);
        vecs[12] = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 32'h4000_1000, 32'h0000_0013, 1'b1, 32'hFFFF_FFFC);
        vecs[13] = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0293, 1'b1, 32'hFFFF_FFFC, 32'h0040_0293, 1'b1, 32'h0000_0000);
        vecs[14] = mk(1'b0, 1'b1, 32'h4000_0102, 1'b1, 32'h0BAD_C0DE, 1'b0, 32'hFFFF_FFFC, 32'h0000_0013, 1'b1, 32'h4000_0100);
        vecs[15] = mk(1'b0, 1'b0, 32'h0, 1'b1, 32'h0050_0313, 1'b1, 32'h4000_0102, 32'h0050_0313, 1'b1, 32'h4000_0104);
        vecs[16] = mk(1'b0, 1'b1, 32'h4000_3000, 1'b0, 32'h0, 1'b0, 32'h4000_0102, 32'h0000_0013, 1'b1, 32'h4000_0104);

        rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
        imem_rdata = 32'h0; imem_resp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all("reset", 1'b0, 32'h4000_0000, 1'b0, 32'h0, 32'h0000_0013, 32'h0);
        rst = 1'b0;
        #1;
        chk("reset_release.read", {31'h0, imem_read}, 32'h1);
        chk("reset_release.addr", imem_address, 32'h4000_0000);

        for (int i = 0; i < 17; i++) begin
            stall_i = vecs[i].stall; redirect_i = vecs[i].redirect; redirect_pc_i = vecs[i].rpc;
            imem_resp = vecs[i].resp; imem_rdata = vecs[i].rdata;
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].erd, vecs[i].eaddr, vecs[i].ev,
                      vecs[i].epc, vecs[i].eir, vecs[i].epc + 32'd4);
        end

        // Reset while a stale request is being drained.
        stall_i = 1'b0; redirect_i = 1'b0; imem_resp = 1'b0; rst = 1'b1;
        @(negedge clk);
        check_all("rst_in_discard", 1'b0, 32'h4000_0000, 1'b0, 32'h0, 32'h0000_0013, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_in_discard_release.read", {31'h0, imem_read}, 32'h1);
        chk("rst_in_discard_release.addr", imem_address, 32'h4000_0000);

        // Randomized traffic against the reference model.
        rst = 1'b1;
        @(negedge clk);
        model_reset();
        r_rst = 1'b0;
        rst = 1'b0;
        lat = 0;
        for (int c = 0; c < 4000; c++) begin
            r_st  = ($urandom_range(0, 99) < 35);
            r_rd  = ($urandom_range(0, 99) < 6);
            r_rpc = $urandom;
            if ($urandom_range(0, 7) == 0) r_rpc = 32'hFFFF_FFFC;
            r_rst = ($urandom_range(0, 399) == 0);
            exp_rd = !r_rst && (mq.size() < 2);
            r_rs  = 1'b0;
            r_dat = $urandom;
            if (r_rst) begin
                lat = 0;
            end else if (exp_rd) begin
                if (lat == 0) begin
                    r_rs = 1'b1;
                    lat  = $urandom_range(0, 3);
                end else begin
                    lat--;
                end
            end
            rst = r_rst; stall_i = r_st; redirect_i = r_rd; redirect_pc_i = r_rpc;
            imem_resp = r_rs; imem_rdata = r_dat;
            #1;
            exp_addr = m_stale ? {m_stale_addr[31:2], 2'b00} : {m_pc[31:2], 2'b00};
            chk("rnd.read_pre", {31'h0, imem_read}, {31'h0, exp_rd});
            chk("rnd.addr_pre", imem_address, exp_addr);
            @(posedge clk);
            model_step(r_rst, r_st, r_rd, r_rpc, r_rs, r_dat);
            @(negedge clk);
            exp_rd   = !rst && (mq.size() < 2);
            exp_addr = m_stale ? {m_stale_addr[31:2], 2'b00} : {m_pc[31:2], 2'b00};
            check_all($sformatf("rnd%0d", c), exp_rd, exp_addr, (mq.size() > 0), m_out_pc,
                      (mq.size() > 0) ? mq[0].ir : 32'h0000_0013,
                      m_loaded ? m_out_pc + 32'd4 : 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
